joypad_reader: RTL and testbench

Serial-to-parallel reader for the standard NES controller port. On request it pulses the controller's latch line, then clocks out P_width serial bits and assembles them into a parallel byte. The byte is held for the $4016/$4017 read path in the CPU bus block. The block is the read-side counterpart to the port's OUT/strobe register: the register drives the strobe, and this block drives the controller clock and collects the data.

---
 rtl/joypad_reader_if.sv | 33 +++
 rtl/joypad_reader.sv | 122 ++++++++++++
 tb/tb_joypad_reader.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/joypad_reader_if.sv
// joypad_reader_if: request/pin/result bundle
// for the NES controller read path.
interface joypad_reader_if #(
    parameter int P_width = 8
);
    logic               I_start;
    logic               I_data;
    logic               O_latch;
    logic               O_clk;
    logic               O_busy;
    logic               O_valid;
    logic [P_width-1:0] O_bits;

    modport master (
        output I_start,
        output I_data,
        input  O_latch,
        input  O_clk,
        input  O_busy,
        input  O_valid,
        input  O_bits
    );

    modport slave (
        input  I_start,
        input  I_data,
        output O_latch,
        output O_clk,
        output O_busy,
        output O_valid,
        output O_bits
    );
endinterface

// File: rtl/joypad_reader.sv
// joypad_reader: latches the NES pad, shifts out
// P_width serial bits and presents them LSB first.
module joypad_reader #(
    parameter int P_width      = 8,
    parameter int P_half       = 6,
    parameter int P_active_low = 1
) (
    input  logic I_clock,
    input  logic I_reset,
    joypad_reader_if.slave bus
);
    localparam int CW = $clog2(P_half + 1);
    localparam int IW =
        (P_width > 1) ? $clog2(P_width) : 1;
    localparam logic [CW-1:0] PH_LAST =
        CW'(P_half - 1);
    localparam logic [IW-1:0] IX_LAST =
        IW'(P_width - 1);
    localparam logic INV = (P_active_low != 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_LOW   = 3'd2;
    localparam logic [2:0] S_HIGH  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]         state;
    logic [CW-1:0]      phase;
    logic [IW-1:0]      index;
    logic               sync1;
    logic               sync2;
    logic [P_width-1:0] shadow;
    logic [P_width-1:0] shadow_next;
    logic [P_width-1:0] bits;
    logic               phase_end;
    logic               bit_in;

    assign phase_end = (phase == PH_LAST);
    assign bit_in    = sync2 ^ INV;

    // Shadow with the current sample merged in.
    always_comb begin
        shadow_next        = shadow;
        shadow_next[index] = bit_in;
    end

    // Two-flop synchronizer for the pad data pin.
    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.I_data;
            sync2 <= sync1;
        end
    end

    // Read sequencer: latch, then LOW/HIGH per bit.
    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            state  <= S_IDLE;
            phase  <= '0;
            index  <= '0;
            shadow <= '0;
            bits   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    phase <= '0;
                    if (bus.I_start)
                        state <= S_LATCH;
                end
                S_LATCH: begin
                    if (phase_end) begin
                        phase <= '0;
                        index <= '0;
                        state <= S_LOW;
                    end else begin
                        phase <= phase + CW'(1);
                    end
                end
                S_LOW: begin
                    if (phase_end) begin
                        phase  <= '0;
                        shadow <= shadow_next;
                        if (index == IX_LAST) begin
                            bits  <= shadow_next;
                            state <= S_DONE;
                        end else begin
                            state <= S_HIGH;
                        end
                    end else begin
                        phase <= phase + CW'(1);
                    end
                end
                S_HIGH: begin
                    if (phase_end) begin
                        phase <= '0;
                        index <= index + IW'(1);
                        state <= S_LOW;
                    end else begin
                        phase <= phase + CW'(1);
                    end
                end
                S_DONE: begin
                    phase <= '0;
                    state <= bus.I_start ? S_LATCH
                                         : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.O_latch = (state == S_LATCH);
    assign bus.O_clk   = (state == S_HIGH);
    assign bus.O_busy  = (state == S_LATCH) ||
                         (state == S_LOW)   ||
                         (state == S_HIGH);
    assign bus.O_valid = (state == S_DONE);
    assign bus.O_bits  = bits;
endmodule

// File: tb/tb_joypad_reader.sv
// tb_joypad_reader: scoreboard bench for the
// NES controller reader.
module tb_joypad_reader;
    localparam int H = 6;
    localparam int W = 8;
    localparam int RD = 2 * H * W + 1;

    typedef struct {
        int         cyc;
        logic [7:0] bits;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    int   lat_n = 0;
    int   clk_hi = 0;
    int   clk_rises = 0;
    logic clk_prev = 1'b0;
    int   c1_clk = 0;

    joypad_reader_if #(.P_width(8)) io ();
    joypad_reader_if #(.P_width(1)) io1 ();

    joypad_reader #(
        .P_width(8), .P_half(6), .P_active_low(1)
    ) dut (
        .I_clock(clk), .I_reset(rst), .bus(io.slave)
    );

    joypad_reader #(
        .P_width(1), .P_half(1), .P_active_low(0)
    ) dut1 (
        .I_clock(clk), .I_reset(rst), .bus(io1.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every O_valid.
    always @(negedge clk) begin
        if (rst) begin
            lat_n     = 0;
            clk_hi    = 0;
            clk_rises = 0;
            clk_prev  = 1'b0;
        end else begin
            if (io.O_latch) lat_n++;
            if (io.O_clk) clk_hi++;
            if (io.O_clk && !clk_prev) clk_rises++;
            clk_prev = io.O_clk;
            if (io.O_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("valid_cycle", cyc, e.cyc);
                    check("bits", io.O_bits, e.bits);
                    check("latch_cycles", lat_n, H);
                    check("clk_pulses", clk_rises, W - 1);
                    check("clk_high_cycles", clk_hi,
                          (W - 1) * H);
                end
                lat_n     = 0;
                clk_hi    = 0;
                clk_rises = 0;
            end
        end
        if (io1.O_clk) c1_clk++;
    end

    // Called at the negedge of cycle 0 of a read.
    task automatic run_read(input logic [7:0] val,
                            input int poke,
                            input bit keep,
                            input int abort);
        exp_t e;
        e.cyc  = cyc + RD;
        e.bits = val;
        q.push_back(e);
        io.I_start = 1'b1;
        for (int k = 1; k <= 2 * H * W; k++) begin
            @(negedge clk);
            if (k == 1 && !keep) io.I_start = 1'b0;
            if (poke > 0 && k == poke)
                io.I_start = 1'b1;
            if (poke > 0 && k == poke + 1)
                io.I_start = 1'b0;
            if ((k - 1) % (2 * H) == 0)
                io.I_data = ~val[(k - 1) / (2 * H)];
            if (k == abort) begin
                rst = 1'b1;
                #1;
                check("abort_clk", io.O_clk, 0);
                check("abort_busy", io.O_busy, 0);
                check("abort_latch", io.O_latch, 0);
                check("abort_bits", io.O_bits, 0);
                void'(q.pop_back());
                repeat (2) @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (k == 1) check("latch_rise", io.O_latch, 1);
            if (k == H + 1)
                check("latch_fall", io.O_latch, 0);
            check("busy_in_read", io.O_busy, 1);
        end
        @(negedge clk);
        check("done_busy", io.O_busy, 0);
        check("done_valid", io.O_valid, 1);
    endtask

    initial begin
        rst         = 1'b1;
        io.I_start  = 1'b0;
        io.I_data   = 1'b0;
        io1.I_start = 1'b0;
        io1.I_data  = 1'b1;

        repeat (3) begin
            @(negedge clk);
            io.I_start = 1'($urandom_range(0, 1));
            io.I_data  = 1'($urandom_range(0, 1));
            check("rst_latch", io.O_latch, 0);
            check("rst_clk", io.O_clk, 0);
            check("rst_busy", io.O_busy, 0);
            check("rst_valid", io.O_valid, 0);
            check("rst_bits", io.O_bits, 0);
        end
        @(negedge clk);
        rst        = 1'b0;
        io.I_start = 1'b0;
        io.I_data  = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_busy", io.O_busy, 0);

        run_read(8'hA5, 0, 0, 0);
        repeat (20) @(negedge clk);
        check("hold_a5", io.O_bits, 8'hA5);

        run_read(8'h5A, 40, 0, 0);
        repeat (120) @(negedge clk);
        check("ignored_bits", io.O_bits, 8'h5A);
        check("ignored_busy", io.O_busy, 0);

        run_read(8'h01, 0, 1, 0);
        run_read(8'h80, 0, 0, 0);
        repeat (5) @(negedge clk);

        run_read(8'h55, 0, 0, 50);
        repeat (100) @(negedge clk);
        check("post_abort_busy", io.O_busy, 0);
        check("post_abort_bits", io.O_bits, 0);
        run_read(8'h3C, 0, 0, 0);
        repeat (5) @(negedge clk);

        c1_clk      = 0;
        io1.I_start = 1'b1;
        @(negedge clk);
        io1.I_start = 1'b0;
        check("c_latch1", io1.O_latch, 1);
        check("c_valid1", io1.O_valid, 0);
        @(negedge clk);
        check("c_latch2", io1.O_latch, 0);
        check("c_busy2", io1.O_busy, 1);
        check("c_valid2", io1.O_valid, 0);
        @(negedge clk);
        check("c_valid3", io1.O_valid, 1);
        check("c_bits3", io1.O_bits, 1);
        check("c_busy3", io1.O_busy, 0);
        @(negedge clk);
        check("c_valid4", io1.O_valid, 0);
        check("c_clk_pulses", c1_clk, 0);

        check("pending", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d",
                 checks, errors);
        $finish;
    end
endmodule
